multi_sprite_engine: RTL

//  N-sprite, 1bpp renderer for the 800x600 SVGA pipeline; sits between the h/v timing generators and the pins.
//  Per-sprite bitmap, position, colour and enable, all written over an SPI slave port.

---
 rtl/multi_sprite_engine_if.sv | 25 ++
 rtl/multi_sprite_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sprite_engine_if.sv
// Video timing inputs, SPI configuration pins and pixel outputs of the sprite engine.
// The master side (timing generator / SPI host) drives; the engine is the slave.
interface multi_sprite_engine_if #(
  parameter int CNT_W = 11
);
  logic signed [CNT_W-1:0] counter_h;
  logic signed [CNT_W-1:0] counter_v;
  logic                    blank;
  logic                    next_frame;
  logic                    spi_sclk;
  logic                    spi_mosi;
  logic                    spi_cs_n;
  logic [5:0]              rrggbb;
  logic                    sprite_hit;

  modport master (
    output counter_h, counter_v, blank, next_frame, spi_sclk, spi_mosi, spi_cs_n,
    input  rrggbb, sprite_hit
  );

  modport slave (
    input  counter_h, counter_v, blank, next_frame, spi_sclk, spi_mosi, spi_cs_n,
    output rrggbb, sprite_hit
  );
endinterface

// File: rtl/multi_sprite_engine.sv
// N-sprite 1bpp renderer with SPI-loaded bitmaps and frame-synchronous position/colour/enable.
// SPI states: IDLE (cs_n high) | CMD (collecting command byte) | DATA (writing sprite) | SKIP (bad index)
module multi_sprite_engine #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPRITE_W    = 10,
  parameter int          SPRITE_H    = 10,
  parameter int          SCALE_LOG2  = 3,
  parameter int          CNT_W       = 11,
  parameter logic [5:0]  BG_COLOR    = 6'b010101
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_sprite_engine_if.slave   bus
);
  localparam int BM_N  = SPRITE_W * SPRITE_H;
  localparam int BI_W  = (BM_N > 1) ? $clog2(BM_N) : 1;
  localparam int PTR_W = BI_W + 4;
  localparam int CMP_W = ((CNT_W > 9) ? CNT_W : 9) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_SKIP} spi_state_e;

  spi_state_e state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] op_q, op_d;
  logic [5:0] idx_q, idx_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [NUM_SPRITES-1:0][BM_N-1:0] bm_q, bm_d;
  logic [NUM_SPRITES-1:0][7:0] shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  logic [NUM_SPRITES-1:0][7:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [NUM_SPRITES-1:0][5:0] shd_col_q, shd_col_d, act_col_q, act_col_d;
  logic [NUM_SPRITES-1:0]      shd_en_q, shd_en_d, act_en_q, act_en_d;
  logic [5:0] rrggbb_q, rrggbb_d;
  logic       hit_q, hit_d;

  logic       sclk_rise, cs_high, cs_fall, mosi_s;
  logic [7:0] shift_nxt;
  logic [PTR_W-1:0] pos;

  assign sclk_sync_d = {sclk_sync_q[1:0], bus.spi_sclk};
  assign cs_sync_d   = {cs_sync_q[1:0], bus.spi_cs_n};
  assign mosi_sync_d = {mosi_sync_q[0], bus.spi_mosi};
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_high     = cs_sync_q[1];
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_s      = mosi_sync_q[1];
  assign shift_nxt   = {shift_q[6:0], mosi_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    op_d       = op_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    ptr_d      = ptr_q;
    bm_d       = bm_q;
    shd_x_d    = shd_x_q;
    shd_y_d    = shd_y_q;
    shd_col_d  = shd_col_q;
    shd_en_d   = shd_en_q;
    act_x_d    = act_x_q;
    act_y_d    = act_y_q;
    act_col_d  = act_col_q;
    act_en_d   = act_en_q;
    pos        = '0;

    if (cs_high) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cs_fall) begin
          state_d    = ST_CMD;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 2'd0;
          ptr_d      = '0;
        end
        ST_CMD: if (sclk_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            op_d    = shift_nxt[7:6];
            idx_d   = shift_nxt[5:0];
            state_d = (int'(shift_nxt[5:0]) < NUM_SPRITES) ? ST_DATA : ST_SKIP;
          end
        end
        ST_DATA: if (sclk_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
            if (op_q == 2'b00 && ptr_q < PTR_W'(BM_N)) ptr_d = ptr_q + PTR_W'(8);
            for (int i = 0; i < NUM_SPRITES; i++) begin
              if (idx_q == 6'(i)) begin
                unique case (op_q)
                  2'b00: for (int j = 0; j < 8; j++) begin
                    // first bit on the wire lands at the lowest bitmap index
                    pos = ptr_q + PTR_W'(j);
                    if (pos < PTR_W'(BM_N)) bm_d[i][pos[BI_W-1:0]] = shift_nxt[7-j];
                  end
                  2'b01: begin
                    if (byte_cnt_q == 2'd0) shd_x_d[i] = shift_nxt;
                    else if (byte_cnt_q == 2'd1) shd_y_d[i] = shift_nxt;
                  end
                  2'b10: if (byte_cnt_q == 2'd0) shd_col_d[i] = shift_nxt[5:0];
                  default: if (byte_cnt_q == 2'd0) shd_en_d[i] = shift_nxt[0];
                endcase
              end
            end
          end
        end
        default: ;
      endcase
    end

    // active copy takes the pre-edge shadow, so a byte landing now waits a frame
    if (bus.next_frame) begin
      act_x_d   = shd_x_q;
      act_y_d   = shd_y_q;
      act_col_d = shd_col_q;
      act_en_d  = shd_en_q;
    end
  end

  logic signed [CNT_W-1:0] hs, vs;
  logic [CMP_W-1:0] hs_u, vs_u, x_lo, x_hi, y_lo, y_hi;
  logic [3:0]       dx, dy;
  logic [BI_W-1:0]  lin;
  logic             in_box, any_hit;
  logic [5:0]       col;

  always_comb begin
    hs      = bus.counter_h >>> SCALE_LOG2;
    vs      = bus.counter_v >>> SCALE_LOG2;
    hs_u    = {{(CMP_W-CNT_W){1'b0}}, hs};
    vs_u    = {{(CMP_W-CNT_W){1'b0}}, vs};
    x_lo    = '0;
    x_hi    = '0;
    y_lo    = '0;
    y_hi    = '0;
    dx      = '0;
    dy      = '0;
    lin     = '0;
    in_box  = 1'b0;
    any_hit = 1'b0;
    col     = BG_COLOR;
    // walk from the highest index down so the lowest-index hit wins
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      x_lo   = {{(CMP_W-8){1'b0}}, act_x_q[i]};
      y_lo   = {{(CMP_W-8){1'b0}}, act_y_q[i]};
      x_hi   = x_lo + CMP_W'(SPRITE_W);
      y_hi   = y_lo + CMP_W'(SPRITE_H);
      in_box = act_en_q[i] && !hs[CNT_W-1] && !vs[CNT_W-1] &&
               hs_u >= x_lo && hs_u < x_hi && vs_u >= y_lo && vs_u < y_hi;
      dx     = 4'(hs_u - x_lo);
      dy     = 4'(vs_u - y_lo);
      lin    = BI_W'(int'(dy) * SPRITE_W + int'(dx));
      if (in_box && bm_q[i][lin]) begin
        any_hit = 1'b1;
        col     = act_col_q[i];
      end
    end
    rrggbb_d = bus.blank ? 6'd0 : col;
    hit_d    = ~bus.blank & any_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      ptr_q       <= '0;
      bm_q        <= '0;
      shd_x_q     <= '0;
      shd_y_q     <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      shd_col_q   <= '1;
      act_col_q   <= '1;
      shd_en_q    <= '0;
      act_en_q    <= '0;
      rrggbb_q    <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      ptr_q       <= ptr_d;
      bm_q        <= bm_d;
      shd_x_q     <= shd_x_d;
      shd_y_q     <= shd_y_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      shd_col_q   <= shd_col_d;
      act_col_q   <= act_col_d;
      shd_en_q    <= shd_en_d;
      act_en_q    <= act_en_d;
      rrggbb_q    <= rrggbb_d;
      hit_q       <= hit_d;
    end
  end

  assign bus.rrggbb     = rrggbb_q;
  assign bus.sprite_hit = hit_q;
endmodule
